// File: rtl/scsi_io_arbiter.sv
// Two-target arbiter in front of a single block IO controller: round-robin grant,
// latched LBA/direction, ack and buffer-write steering, mount routing and an ack watchdog.
module scsi_io_arbiter #(
    parameter logic [23:0] WD_CYCLES = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] t0_lba,
    input  logic        t0_rd,
    input  logic        t0_wr,
    output logic        t0_ack,
    input  logic [7:0]  t0_buff_din,
    output logic        t0_buff_wr,
    output logic        t0_mounted,
    input  logic [31:0] t1_lba,
    input  logic        t1_rd,
    input  logic        t1_wr,
    output logic        t1_ack,
    input  logic [7:0]  t1_buff_din,
    output logic        t1_buff_wr,
    output logic        t1_mounted,
    output logic [31:0] io_lba,
    output logic        io_rd,
    output logic        io_wr,
    input  logic        io_ack,
    output logic [7:0]  sd_buff_din,
    input  logic        sd_buff_wr,
    input  logic        img_mounted,
    input  logic        img_id,
    output logic        io_timeout
);

    typedef enum logic [1:0] {IDLE, REQ, ACK, REL} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic        dir_rd_q, dir_rd_d;
    logic [31:0] lat_lba_q, lat_lba_d;
    logic [23:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;
    logic        t0_mounted_q, t0_mounted_d;
    logic        t1_mounted_q, t1_mounted_d;

    logic t0_pend, t1_pend, grant_t1, owner_pend, wd_expire, busy, fwd_ack, fwd_wr;

    assign t0_pend    = t0_rd | t0_wr;
    assign t1_pend    = t1_rd | t1_wr;
    // On a tie the target that was not served last wins.
    assign grant_t1   = t1_pend & (~t0_pend | ~last_owner_q);
    assign owner_pend = owner_q ? t1_pend : t0_pend;
    assign wd_expire  = (WD_CYCLES != 24'd0) && (wd_cnt_q == WD_CYCLES - 24'd1);
    assign busy       = (state_q == REQ) || (state_q == ACK);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        dir_rd_d     = dir_rd_q;
        lat_lba_d    = lat_lba_q;
        wd_cnt_d     = wd_cnt_q;
        timeout_d    = 1'b0;
        t0_mounted_d = img_mounted & ~img_id;
        t1_mounted_d = img_mounted & img_id;
        case (state_q)
            IDLE: begin
                if (t0_pend || t1_pend) begin
                    owner_d   = grant_t1;
                    lat_lba_d = grant_t1 ? t1_lba : t0_lba;
                    dir_rd_d  = grant_t1 ? t1_rd : t0_rd;
                    wd_cnt_d  = 24'd0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (wd_expire) begin
                    timeout_d = 1'b1;
                    state_d   = REL;
                end else begin
                    wd_cnt_d = wd_cnt_q + 24'd1;
                    if (io_ack)
                        state_d = ACK;
                    else if (!owner_pend)
                        state_d = REL;
                end
            end
            ACK: begin
                if (wd_expire) begin
                    timeout_d = 1'b1;
                    state_d   = REL;
                end else begin
                    wd_cnt_d = wd_cnt_q + 24'd1;
                    if (!io_ack)
                        state_d = REL;
                end
            end
            REL: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            dir_rd_q     <= 1'b0;
            lat_lba_q    <= 32'd0;
            wd_cnt_q     <= 24'd0;
            timeout_q    <= 1'b0;
            t0_mounted_q <= 1'b0;
            t1_mounted_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            dir_rd_q     <= dir_rd_d;
            lat_lba_q    <= lat_lba_d;
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= timeout_d;
            t0_mounted_q <= t0_mounted_d;
            t1_mounted_q <= t1_mounted_d;
        end
    end

    // Strobes are forced low while rst is high so a reset mid-transfer is silent at once.
    assign fwd_ack = io_ack & busy & ~rst;
    assign fwd_wr  = sd_buff_wr & (state_q != IDLE) & ~rst;

    assign io_lba      = lat_lba_q;
    assign io_rd       = (state_q == REQ) & dir_rd_q & ~rst;
    assign io_wr       = (state_q == REQ) & ~dir_rd_q & ~rst;
    assign t0_ack      = fwd_ack & ~owner_q;
    assign t1_ack      = fwd_ack & owner_q;
    assign t0_buff_wr  = fwd_wr & ~owner_q;
    assign t1_buff_wr  = fwd_wr & owner_q;
    assign sd_buff_din = owner_q ? t1_buff_din : t0_buff_din;
    assign t0_mounted  = t0_mounted_q;
    assign t1_mounted  = t1_mounted_q;
    assign io_timeout  = timeout_q & ~rst;

endmodule
